// File: rtl/readout_seq.sv
// Readout sequencer: streams sample RAM backwards, newest first, into tuart_tx.
// Optional abort input enabled by defining READOUT_SEQ_ABORT_EN.
module readout_seq #(
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned CMD_WORDS = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic                           start_i,
  input  logic [ADDR_BITS-1:0]           start_addr_i,
  input  logic [ADDR_BITS-1:0]           read_cnt_i,
  output logic                           rd_o,
  output logic [ADDR_BITS-1:0]           addr_o,
  input  logic [WORD_BITS*CMD_WORDS-1:0] rdata_i,
  output logic                           tx_stb_o,
  input  logic                           tx_rdy_i,
  output logic [WORD_BITS*CMD_WORDS-1:0] tx_data_o,
  output logic                           busy_o,
`ifdef READOUT_SEQ_ABORT_EN
  input  logic                           abort_i,
`endif
  output logic                           done_o
);

  localparam int unsigned SW = WORD_BITS * CMD_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WAIT_RDY,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS-1:0]  r_rem;
  logic [SW-1:0]         r_data;
  logic                  r_rd;
  logic                  r_stb;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_abort_pend;
  logic                  w_abort;

`ifdef READOUT_SEQ_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Next-state logic; an abort during WAIT_ACK is deferred until the handshake finishes
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_next = S_READ;
      S_READ:     w_next = w_abort ? S_IDLE : S_LATCH;
      S_LATCH:    w_next = w_abort ? S_IDLE : S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (w_abort)       w_next = S_IDLE;
        else if (tx_rdy_i) w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!tx_rdy_i) begin
          if (r_abort_pend || w_abort) w_next = S_IDLE;
          else if (r_rem == '0)        w_next = S_DONE;
          else                         w_next = S_READ;
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rem        <= '0;
      r_data       <= '0;
      r_rd         <= 1'b0;
      r_stb        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd    <= (w_next == S_READ);
      r_stb   <= (r_state == S_WAIT_RDY) && (w_next == S_WAIT_ACK);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);

      if (w_next == S_IDLE)
        r_abort_pend <= 1'b0;
      else if ((r_state == S_WAIT_ACK) && w_abort)
        r_abort_pend <= 1'b1;

      if ((r_state == S_IDLE) && start_i) begin
        r_addr <= start_addr_i;
        r_rem  <= read_cnt_i;
      end else if ((r_state == S_WAIT_ACK) && (w_next == S_READ)) begin
        r_addr <= r_addr - ADDR_BITS'(1);
        r_rem  <= r_rem - ADDR_BITS'(1);
      end

      // RAM data is valid the cycle after the read strobe
      if (r_state == S_LATCH)
        r_data <= rdata_i;
    end
  end

  assign rd_o      = r_rd;
  assign addr_o    = r_addr;
  assign tx_stb_o  = r_stb;
  assign tx_data_o = r_data;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_readout_seq.sv
// Scoreboard bench for readout_seq with a RAM model and a tuart_tx rdy/stb model.
module tb_readout_seq;

  localparam int unsigned AW = 10;
  localparam int unsigned SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] read_cnt;
  logic          rd_o;
  logic [AW-1:0] addr_o;
  logic [SW-1:0] rdata;
  logic          tx_stb;
  logic          tx_rdy;
  logic [SW-1:0] tx_data;
  logic          busy;
  logic          done;
  logic          abort_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [SW-1:0] mem [1024];
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] obs_addr[$];
  logic [SW-1:0] exp_data[$];
  logic [SW-1:0] obs_data[$];
  int stb_cnt, bad_stb, done_cnt;
  int tu_hold;
  int tu_cnt;
  logic tu_rdy;
  logic tb_block;

  always #5 clk = ~clk;

  readout_seq dut (
    .clk_i       (clk),
    .rst_in      (rst_n),
    .start_i     (start_i),
    .start_addr_i(start_addr),
    .read_cnt_i  (read_cnt),
    .rd_o        (rd_o),
    .addr_o      (addr_o),
    .rdata_i     (rdata),
    .tx_stb_o    (tx_stb),
    .tx_rdy_i    (tx_rdy),
    .tx_data_o   (tx_data),
    .busy_o      (busy),
`ifdef READOUT_SEQ_ABORT_EN
    .abort_i     (abort_i),
`endif
    .done_o      (done)
  );

  // synchronous-read RAM model
  always @(posedge clk) if (rd_o) rdata <= mem[addr_o];

  // tuart_tx model: rdy drops on an accepted strobe for tu_hold cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tu_rdy <= 1'b1;
      tu_cnt <= 0;
    end else if (tx_stb && tx_rdy) begin
      tu_rdy <= 1'b0;
      tu_cnt <= tu_hold;
    end else if (!tu_rdy) begin
      if (tu_cnt <= 1) tu_rdy <= 1'b1;
      else             tu_cnt <= tu_cnt - 1;
    end
  end
  assign tx_rdy = tu_rdy & ~tb_block;

  // observation collector
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_o) obs_addr.push_back(addr_o);
      if (tx_stb) begin
        obs_data.push_back(tx_data);
        stb_cnt++;
        if (!tx_rdy) bad_stb++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_sb();
    exp_addr.delete(); obs_addr.delete();
    exp_data.delete(); obs_data.delete();
    stb_cnt = 0; bad_stb = 0; done_cnt = 0;
  endtask

  task automatic start_run(input logic [AW-1:0] a0, input logic [AW-1:0] c);
    logic [AW-1:0] a;
    a = a0;
    for (int i = 0; i <= int'(c); i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
      a = a - AW'(1);
    end
    @(negedge clk);
    start_i = 1'b1; start_addr = a0; read_cnt = c;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_stb(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stb_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rd_o, tx_stb, busy, done} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {rd_o, tx_stb, busy, done});
    end
    n_cmp++;
    if (addr_o !== '0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", addr_o); end
    n_cmp++;
    if (tx_data !== '0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", tx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    tu_hold = 50;
    mem[5] = 32'h11223344; mem[4] = 32'hAABBCCDD; mem[3] = 32'h0F0F0F0F;
    clear_sb();
    start_run(10'd5, 10'd2);
    wait_done(1000, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_done: got %0d expected 1", ok); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL basic_nrd: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front(); o = obs_addr.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_addr: got %0d expected %0d", o, e); end
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [SW-1:0] e, o;
      e = exp_data.pop_front(); o = obs_data.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_data: got %0h expected %0h", o, e); end
    end
    n_cmp++;
    if (stb_cnt !== 3) begin n_err++; $display("FAIL basic_nstb: got %0d expected 3", stb_cnt); end
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL basic_ndone: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b expected 0", busy); end
    n_cmp++;
    if (bad_stb !== 0) begin n_err++; $display("FAIL basic_stb_rdy_low: got %0d expected 0", bad_stb); end
  endtask

  task automatic test_wrap();
    bit ok;
    tu_hold = 5;
    clear_sb();
    start_run(10'd1, 10'd3);
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || stb_cnt !== 4) begin
      n_err++; $display("FAIL wrap_count: got done=%0d stb=%0d expected done=1 stb=4", ok, stb_cnt);
    end
    n_cmp++;
    if (obs_addr.size() != 4) begin n_err++; $display("FAIL wrap_nrd: got %0d expected 4", obs_addr.size()); end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front(); o = obs_addr.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL wrap_addr: got %0d expected %0d", o, e); end
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [SW-1:0] e, o;
      e = exp_data.pop_front(); o = obs_data.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL wrap_data: got %0h expected %0h", o, e); end
    end
  endtask

  task automatic test_single();
    bit ok;
    tu_hold = 5;
    clear_sb();
    start_run(10'd20, 10'd0);
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 10'd20) begin
      n_err++; $display("FAIL single_rd: got n=%0d expected n=1 at addr 20", obs_addr.size());
    end
    n_cmp++;
    if (stb_cnt !== 1 || done_cnt !== 1) begin
      n_err++; $display("FAIL single_hs: got stb=%0d done=%0d expected 1/1", stb_cnt, done_cnt);
    end
    n_cmp++;
    if (obs_data.size() != 1 || obs_data[0] !== mem[20]) begin
      n_err++; $display("FAIL single_data: got n=%0d expected one sample %0h", obs_data.size(), mem[20]);
    end
  endtask

  task automatic test_full_ram();
    bit ok;
    int miss;
    tu_hold = 2;
    clear_sb();
    start_run(10'd7, 10'h3FF);
    wait_done(20000, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || stb_cnt !== 1024) begin
      n_err++; $display("FAIL full_count: got done=%0d stb=%0d expected 1/1024", ok, stb_cnt);
    end
    miss = 0;
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front(); o = obs_addr.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; miss++;
        if (miss < 5) $display("FAIL full_addr: got %0d expected %0d", o, e);
      end
    end
    n_cmp++;
    if (obs_addr.size() != 0 || exp_addr.size() != 0) begin
      n_err++; $display("FAIL full_leftover: got obs=%0d exp=%0d expected 0/0", obs_addr.size(), exp_addr.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [SW-1:0] d0;
    int s0;
    tu_hold = 5;
    clear_sb();
    start_run(10'd300, 10'd2);
    wait_stb(1, 200, ok);
    tb_block = 1'b1;
    s0 = stb_cnt;
    repeat (20) @(negedge clk);
    d0 = tx_data;
    n_cmp++;
    if (d0 !== mem[299]) begin n_err++; $display("FAIL bp_latched: got %0h expected %0h", d0, mem[299]); end
    stable = 1'b1;
    for (int i = 0; i < 980; i++) begin
      @(negedge clk);
      if (tx_data !== d0) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %0d expected 1", stable); end
    n_cmp++;
    if (stb_cnt !== s0 || bad_stb !== 0) begin
      n_err++; $display("FAIL bp_nostb: got stb=%0d bad=%0d expected %0d/0", stb_cnt, bad_stb, s0);
    end
    tb_block = 1'b0;
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || stb_cnt !== 3) begin
      n_err++; $display("FAIL bp_resume: got done=%0d stb=%0d expected 1/3", ok, stb_cnt);
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      logic [SW-1:0] e, o;
      e = exp_data.pop_front(); o = obs_data.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_data: got %0h expected %0h", o, e); end
    end
  endtask

  task automatic test_start_rules();
    bit ok;
    tu_hold = 5;
    clear_sb();
    start_run(10'd50, 10'd1);
    @(negedge clk);
    start_i = 1'b1; start_addr = 10'd900; read_cnt = 10'd5;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(300, ok);
    start_i = 1'b1; start_addr = 10'd600; read_cnt = 10'd0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || stb_cnt !== 2) begin
      n_err++; $display("FAIL start_busy_ignored: got done=%0d stb=%0d expected 1/2", ok, stb_cnt);
    end
    n_cmp++;
    if (obs_addr.size() != 2) begin n_err++; $display("FAIL start_nrd: got %0d expected 2", obs_addr.size()); end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front(); o = obs_addr.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL start_addr: got %0d expected %0d", o, e); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_on_done_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    tu_hold = 5;
    clear_sb();
    start_run(10'd100, 10'd3);
    wait_stb(2, 300, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rst_reach: got %0d expected 1", ok); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_o, tx_stb, busy, done} !== 4'b0 || addr_o !== '0 || tx_data !== '0) begin
      n_err++; $display("FAIL rst_outputs: got ctrl=%b addr=%0h data=%0h expected zeros",
                        {rd_o, tx_stb, busy, done}, addr_o, tx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (stb_cnt !== 2 || done_cnt !== 0) begin
      n_err++; $display("FAIL rst_quiet: got stb=%0d done=%0d expected 2/0", stb_cnt, done_cnt);
    end
    clear_sb();
    start_run(10'd200, 10'd1);
    wait_done(300, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || obs_addr.size() != 2) begin
      n_err++; $display("FAIL rst_restart: got done=%0d nrd=%0d expected 1/2", ok, obs_addr.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] e, o;
      e = exp_addr.pop_front(); o = obs_addr.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rst_restart_addr: got %0d expected %0d", o, e); end
    end
  endtask

`ifdef READOUT_SEQ_ABORT_EN
  task automatic test_abort();
    bit ok;
    tu_hold = 10;
    clear_sb();
    tb_block = 1'b1;
    start_run(10'd400, 10'd2);
    repeat (8) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_rdy_idle: got busy=%b expected 0", busy); end
    tb_block = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (stb_cnt !== 0 || done_cnt !== 0 || obs_addr.size() != 1) begin
      n_err++; $display("FAIL abort_rdy: got stb=%0d done=%0d nrd=%0d expected 0/0/1",
                        stb_cnt, done_cnt, obs_addr.size());
    end
    clear_sb();
    start_run(10'd410, 10'd3);
    wait_stb(1, 200, ok);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || stb_cnt !== 1 || obs_addr.size() != 1 || done_cnt !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_ack: got stb=%0d nrd=%0d done=%0d busy=%b expected 1/1/0/0",
                        stb_cnt, obs_addr.size(), done_cnt, busy);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start_i = 1'b0; start_addr = '0; read_cnt = '0;
    abort_i = 1'b0; tb_block = 1'b0; tu_hold = 5;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h1357_9BDF;
    clear_sb();
    test_reset();
    test_basic();
    test_wrap();
    test_single();
    test_full_ram();
    test_backpressure();
    test_start_rules();
    test_reset_midrun();
`ifdef READOUT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/readout_seq.md
Name: readout_seq

Overview:
- Readout sequencer directly upstream of tuart_tx.
- On a start pulse it walks the sample RAM backwards from a given address, newest sample first.
- It fetches one CMD_WORDS*WORD_BITS sample per RAM read and hands each sample to tuart_tx through its stb/rdy handshake.
- Used after a capture completes to stream the buffer to the host.

Parameters:
- WORD_BITS, 8, bits per UART word (must match tuart_tx)
- CMD_WORDS, 4, words per sample; sample width SW = CMD_WORDS*WORD_BITS
- ADDR_BITS, 10, sample RAM address width; RAM depth 2**ADDR_BITS

Ports:
- clk_i  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start pulse; ignored while busy_o=1
- start_addr_i  in  ADDR_BITS  address of the first (newest) sample, sampled on start_i
- read_cnt_i  in  ADDR_BITS  samples to send minus one, sampled on start_i
- rd_o  in→out  1  RAM read enable
- addr_o  out  ADDR_BITS  RAM read address
- rdata_i  in  SW  RAM read data, valid one cycle after rd_o
- tx_stb_o  out  1  to tuart_tx stb_i
- tx_rdy_i  in  1  from tuart_tx rdy_o
- tx_data_o  out  SW  to tuart_tx data_i
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE
- done_o  out  1  single-cycle pulse after the last sample is handed off

Behaviour:
- Reset, asynchronous, rst_in=0:
  - state=IDLE.
  - rd_o, tx_stb_o, busy_o, done_o = 0.
  - addr_o, tx_data_o, remaining counter = 0.
  - Reset mid-readout aborts immediately; no further strobes until a new start_i.
- IDLE:
  - On start_i=1, latch addr := start_addr_i and rem := read_cnt_i, then go to READ.
- READ:
  - rd_o=1 for exactly one cycle, addr_o=addr, then go to LATCH.
- LATCH:
  - tx_data_o := rdata_i, registered, then go to WAIT_RDY.
- WAIT_RDY:
  - Stay while tx_rdy_i=0.
  - When tx_rdy_i=1, drive tx_stb_o=1 for one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - Stay while tx_rdy_i=1.
  - When tx_rdy_i=0 (tuart_tx has accepted and started):
    - If rem=0, go to DONE.
    - Otherwise rem := rem-1, addr := addr-1 modulo 2**ADDR_BITS (0 wraps to all-ones), and go to READ.
- DONE:
  - done_o=1 for one cycle, then go to IDLE; busy_o falls in the same cycle IDLE is entered.
- Handshake invariants:
  - tx_data_o stays stable from the LATCH update until the next LATCH.
  - tx_stb_o never asserts while tx_rdy_i=0.
  - tx_stb_o never asserts twice for one sample.
- Counting:
  - Total strobes per run = read_cnt_i+1.
  - Range is 1 to 2**ADDR_BITS samples; read_cnt_i=all-ones reads the whole RAM once, each address exactly once.
- Minimum per-sample overhead is 4 cycles (READ, LATCH, WAIT_RDY, WAIT_ACK) plus the tuart_tx busy time.
- XON/XOFF stalls are handled inside tuart_tx. Here they appear only as long tx_rdy_i=0 periods; no timeout.
- start_i in the same cycle as done_o is ignored; start is accepted only in IDLE.

Optional Feature:
- Macro: READOUT_SEQ_ABORT_EN
- With the macro: adds input abort_i (1 bit, single-cycle pulse).
  - Asserted in IDLE: no effect.
  - Asserted in READ, LATCH or WAIT_RDY before the strobe: return to IDLE next cycle with no strobe issued.
  - Asserted in WAIT_ACK: the in-flight sample completes its handshake, then return to IDLE.
  - On any abort, done_o is not pulsed and busy_o falls on IDLE entry.
- Without the macro: no abort_i port; a run always completes or is ended by reset.

Test Plan:
- Basic run:
  - Stimulus: start_addr_i=5, read_cnt_i=2; RAM[5,4,3]=32'h11223344, 32'hAABBCCDD, 32'h0F0F0F0F; tuart model holds rdy low 50 cycles per strobe.
  - Required: addresses read in order 5,4,3; exactly 3 strobes carrying those data values; one done_o pulse; busy_o low afterwards.
- Wrap-around:
  - Stimulus: start_addr_i=1, read_cnt_i=3.
  - Required: addresses 1, 0, 1023, 1022; 4 strobes.
- Single sample:
  - Stimulus: read_cnt_i=0.
  - Required: exactly 1 rd_o pulse, 1 strobe, then done_o.
- Backpressure:
  - Stimulus: hold tx_rdy_i=0 for 1000 cycles before the 2nd sample.
  - Required: no strobe while rdy low; tx_data_o stable throughout; run resumes and completes.
- Reset and start rules:
  - Stimulus: assert rst_in=0 during WAIT_ACK of sample 2 of 4.
  - Required: all outputs 0 immediately; no done_o; a new start afterwards begins at the new start_addr_i.
  - Stimulus: start_i pulsed while busy_o=1.
  - Required: ignored.
- Abort (READOUT_SEQ_ABORT_EN defined):
  - Stimulus: abort_i in WAIT_RDY.
  - Required: no strobe, IDLE next cycle, no done_o.
  - Stimulus: abort_i in WAIT_ACK.
  - Required: current handshake completes, no further rd_o, no done_o.
